// File: rtl/processor_pkg.sv
// Shared processor definitions: sequencer state encoding and the default datapath width.
package processor_pkg;

    localparam int PROC_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LOAD_HOLD,
        SHIFT,
        HOLD
    } seq_state_t;

endpackage

// File: rtl/shift_counter.sv
// Counts shifts issued in the current sequence; saturates at WIDTH and flags the final shift.
module shift_counter
    import processor_pkg::*;
#(
    parameter int WIDTH = PROC_WIDTH
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         clear,
    input  logic                         enable,
    output logic [$clog2(WIDTH+1)-1:0]   count,
    output logic                         tc
);

    localparam int CW = $clog2(WIDTH + 1);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CW'(WIDTH))) begin
            count <= count + CW'(1);
        end
    end

    // tc marks the cycle whose shift is the last one, so the FSM can leave on that edge
    assign tc = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/execute_sequencer.sv
// Control unit for the shift-add datapath: one Execute press yields exactly WIDTH shifts,
// one ClearA_LoadB press yields exactly one Clr_A/Ld_B pulse.
module execute_sequencer
    import processor_pkg::*;
#(
    parameter int WIDTH = PROC_WIDTH
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         Execute,
    input  logic                         ClearA_LoadB,
    output logic                         Shift_En,
    output logic                         Ld_B,
    output logic                         Clr_A,
    output logic                         Busy,
    output logic                         Done,
    output logic [$clog2(WIDTH+1)-1:0]   Count
);

    seq_state_t state;
    seq_state_t state_next;
    logic       cnt_clear;
    logic       cnt_en;
    logic       tc;

    shift_counter #(
        .WIDTH (WIDTH)
    ) u_shift_counter (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .count   (Count),
        .tc      (tc)
    );

    // Count restarts only when a sequence starts; it holds in every other non-shift state
    assign cnt_clear = (state == IDLE) && Execute;
    assign cnt_en    = (state == SHIFT);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (Execute) begin
                    state_next = SHIFT;
                end else if (ClearA_LoadB) begin
                    state_next = LOAD;
                end
            end
            LOAD:      state_next = LOAD_HOLD;
            LOAD_HOLD: if (!ClearA_LoadB) state_next = IDLE;
            SHIFT:     if (tc) state_next = HOLD;
            HOLD:      if (!Execute) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            Shift_En <= 1'b0;
            Busy     <= 1'b0;
            Ld_B     <= 1'b0;
            Clr_A    <= 1'b0;
            Done     <= 1'b0;
        end else begin
            state    <= state_next;
            Shift_En <= (state_next == SHIFT);
            Busy     <= (state_next == SHIFT);
            Ld_B     <= (state_next == LOAD);
            Clr_A    <= (state_next == LOAD);
            Done     <= (state_next == HOLD);
        end
    end

endmodule

// File: tb/tb_execute_sequencer.sv
// Bench for execute_sequencer: WIDTH=8 and WIDTH=4 instances against an abstract sequence model.
module tb_execute_sequencer;

    logic       Clk;
    logic       Reset_n;
    logic       Execute;
    logic       ClearA_LoadB;

    logic       Shift_En8, Ld_B8, Clr_A8, Busy8, Done8;
    logic [3:0] Count8;
    logic       Shift_En4, Ld_B4, Clr_A4, Busy4, Done4;
    logic [2:0] Count4;

    int n_pass  = 0;
    int n_total = 0;

    // Model: shifts remaining, shifts done, done flag, load pulse pending, load button still held
    int m_rem   [2];
    int m_cnt   [2];
    bit m_done  [2];
    bit m_lp    [2];
    bit m_lw    [2];
    int wd      [2] = '{8, 4};

    int sh8, sh4, ld8, clr8, dn8;

    execute_sequencer #(.WIDTH(8)) dut8 (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Execute      (Execute),
        .ClearA_LoadB (ClearA_LoadB),
        .Shift_En     (Shift_En8),
        .Ld_B         (Ld_B8),
        .Clr_A        (Clr_A8),
        .Busy         (Busy8),
        .Done         (Done8),
        .Count        (Count8)
    );

    execute_sequencer #(.WIDTH(4)) dut4 (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Execute      (Execute),
        .ClearA_LoadB (ClearA_LoadB),
        .Shift_En     (Shift_En4),
        .Ld_B         (Ld_B4),
        .Clr_A        (Clr_A4),
        .Busy         (Busy4),
        .Done         (Done4),
        .Count        (Count4)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [12:0] pk(input logic s, input logic l, input logic c,
                                       input logic b, input logic d, input logic [7:0] cnt);
        return {s, l, c, b, d, cnt};
    endfunction

    function automatic logic [12:0] exp_vec(input int i);
        return pk(m_rem[i] > 0, m_lp[i], m_lp[i], m_rem[i] > 0, m_done[i], 8'(m_cnt[i]));
    endfunction

    always @(posedge Clk or negedge Reset_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!Reset_n) begin
                m_rem[i] = 0; m_cnt[i] = 0; m_done[i] = 0; m_lp[i] = 0; m_lw[i] = 0;
            end else if (m_rem[i] > 0) begin
                m_cnt[i]++;
                m_rem[i]--;
                if (m_rem[i] == 0) m_done[i] = 1;
            end else if (m_done[i]) begin
                if (!Execute) m_done[i] = 0;
            end else if (m_lp[i]) begin
                m_lp[i] = 0;
                m_lw[i] = 1;
            end else if (m_lw[i]) begin
                if (!ClearA_LoadB) m_lw[i] = 0;
            end else if (Execute) begin
                m_rem[i] = wd[i];
                m_cnt[i] = 0;
            end else if (ClearA_LoadB) begin
                m_lp[i] = 1;
            end
        end
    end

    always begin
        @(posedge Clk);
        #2;
        check("cycle_w8", pk(Shift_En8, Ld_B8, Clr_A8, Busy8, Done8, {4'b0, Count8}), exp_vec(0));
        check("cycle_w4", pk(Shift_En4, Ld_B4, Clr_A4, Busy4, Done4, {5'b0, Count4}), exp_vec(1));
    end

    task automatic tick();
        @(posedge Clk);
        #2;
        if (Shift_En8) sh8++;
        if (Shift_En4) sh4++;
        if (Ld_B8)     ld8++;
        if (Clr_A8)    clr8++;
        if (Done8)     dn8++;
    endtask

    task automatic clr_stats();
        sh8 = 0; sh4 = 0; ld8 = 0; clr8 = 0; dn8 = 0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n      = 1'b1;
        Execute      = 1'b0;
        ClearA_LoadB = 1'b0;
        clr_stats();
        #1 Reset_n = 1'b0;
        ticks(2);
        check("reset_outs_w8", pk(Shift_En8, Ld_B8, Clr_A8, Busy8, Done8, {4'b0, Count8}), 13'h0);
        check("reset_outs_w4", pk(Shift_En4, Ld_B4, Clr_A4, Busy4, Done4, {5'b0, Count4}), 13'h0);
        #1 Reset_n = 1'b1;

        // Execute held for 20 cycles
        clr_stats();
        Execute = 1'b1;
        tick();
        check("first_shift_en", Shift_En8, 1'b1);
        check("first_shift_cnt", Count8, 4'd0);
        ticks(19);
        check("a_shifts_w8", sh8, 8);
        check("a_shifts_w4", sh4, 4);
        check("a_done_cycles", dn8, 12);
        check("a_hold_count_w8", Count8, 4'd8);
        check("a_hold_count_w4", Count4, 3'd4);
        check("a_hold_done", Done8, 1'b1);
        Execute = 1'b0;
        tick();
        check("a_idle_done", Done8, 1'b0);
        check("a_idle_count_kept", Count8, 4'd8);

        // ClearA_LoadB held for 10 cycles, released, pressed again
        clr_stats();
        ClearA_LoadB = 1'b1;
        ticks(10);
        check("b_ldb_pulses", ld8, 1);
        check("b_clra_pulses", clr8, 1);
        check("b_no_shift", sh8, 0);
        ClearA_LoadB = 1'b0;
        ticks(2);
        ClearA_LoadB = 1'b1;
        ticks(10);
        check("b_second_press", ld8, 2);
        check("b_count_kept", Count8, 4'd8);
        ClearA_LoadB = 1'b0;
        ticks(2);

        // Both buttons in the same cycle: Execute wins
        clr_stats();
        Execute      = 1'b1;
        ClearA_LoadB = 1'b1;
        tick();
        check("c_shift_entered", Shift_En8, 1'b1);
        check("c_no_ldb", Ld_B8, 1'b0);
        ticks(9);
        Execute      = 1'b0;
        ClearA_LoadB = 1'b0;
        ticks(3);
        check("c_shifts", sh8, 8);
        check("c_no_load_pulse", ld8, 0);
        check("c_idle_busy", Busy8, 1'b0);

        // Execute pulsed, then pulsed again during shift 4
        clr_stats();
        Execute = 1'b1;
        tick();
        Execute = 1'b0;
        ticks(2);
        Execute = 1'b1;
        tick();
        Execute = 1'b0;
        ticks(12);
        check("d_shifts_w8", sh8, 8);
        check("d_shifts_w4", sh4, 4);
        check("d_done_cycles", dn8, 1);
        check("d_final_idle", pk(Shift_En8, Ld_B8, Clr_A8, Busy8, Done8, {4'b0, Count8}),
              pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd8));

        // Asynchronous reset in the middle of shift 5
        Execute = 1'b1;
        ticks(5);
        check("e_shift5_count", Count8, 4'd4);
        #1 Reset_n = 1'b0;
        #1;
        check("e_async_w8", pk(Shift_En8, Ld_B8, Clr_A8, Busy8, Done8, {4'b0, Count8}), 13'h0);
        check("e_async_w4", pk(Shift_En4, Ld_B4, Clr_A4, Busy4, Done4, {5'b0, Count4}), 13'h0);
        Execute = 1'b0;
        tick();
        #1 Reset_n = 1'b1;
        tick();
        check("e_idle_after", pk(Shift_En8, Ld_B8, Clr_A8, Busy8, Done8, {4'b0, Count8}), 13'h0);

        // Reset released with Execute held starts a sequence on the first edge
        #1 Reset_n = 1'b0;
        Execute = 1'b1;
        tick();
        #1 Reset_n = 1'b1;
        tick();
        check("f_start_after_reset", Shift_En8, 1'b1);
        check("f_start_count", Count8, 4'd0);
        Execute = 1'b0;
        ticks(10);

        // Reset released with ClearA_LoadB held performs one load
        #1 Reset_n = 1'b0;
        ClearA_LoadB = 1'b1;
        tick();
        clr_stats();
        #1 Reset_n = 1'b1;
        ticks(5);
        check("g_load_after_reset", ld8, 1);
        ClearA_LoadB = 1'b0;
        ticks(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
